mem_stage: RTL

Memory stage of the Y86-64 SEQ datapath, directly downstream of the execute stage. Takes the instruction code, the ALU result `val_e`, `val_a` and the return address `val_p`, and performs at most one 64-bit data-memory read or write per instruction on an internal word array. It returns `val_m` and the machine status, with a start/done handshake and a sticky stop state for halts and faults.

---
 rtl/mem_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the Y86-64 SEQ datapath.
// Does at most one 64-bit read or write per instruction on an internal word array.
// The instruction is latched in IDLE, the access happens in ACCESS and the result is reported in RESP.
// HLT, ADR and INS send the stage to a STOP state that only reset leaves.
// Optional macro MEM_ALIGN_CHECK_EN: when defined, an access with addr[2:0] != 0 faults with ADR.
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  in_code,
  input  logic [63:0] val_e,
  input  logic [63:0] val_a,
  input  logic [63:0] val_p,
  output logic        busy,
  output logic        done,
  output logic [63:0] val_m,
  output logic [2:0]  stat
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'd8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, STOP} state_t;
  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_t;

  state_t      state, state_nx;
  stat_t       stat_q, acc_stat;
  logic [3:0]  code_q;
  logic [63:0] e_q, a_q, p_q;
  logic [63:0] val_m_q;

  logic        is_rd, is_wr, bad_addr, we;
  logic [63:0] addr, wdata, rdata;
  logic [AW-1:0] idx;

  logic [63:0] mem [DEPTH_WORDS];

  // Decode the latched icode into the access type, address, store data and status.
  always_comb begin
    is_rd    = 1'b0;
    is_wr    = 1'b0;
    addr     = '0;
    wdata    = '0;
    acc_stat = S_AOK;
    case (code_q)
      4'd0:                     acc_stat = S_HLT;
      4'd1, 4'd2, 4'd3,
      4'd6, 4'd7:               acc_stat = S_AOK;
      4'd4:  begin is_wr = 1'b1; addr = e_q; wdata = a_q; end
      4'd5:  begin is_rd = 1'b1; addr = e_q;              end
      4'd8:  begin is_wr = 1'b1; addr = e_q; wdata = p_q; end
      4'd9:  begin is_rd = 1'b1; addr = a_q;              end
      4'd10: begin is_wr = 1'b1; addr = e_q; wdata = a_q; end
      4'd11: begin is_rd = 1'b1; addr = a_q;              end
      default:                  acc_stat = S_INS;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    bad_addr = (is_rd || is_wr) && ((addr >= LIMIT) || (addr[2:0] != 3'd0));
`else
    bad_addr = (is_rd || is_wr) && (addr >= LIMIT);
`endif
    if (bad_addr)
      acc_stat = S_ADR;
  end

  assign idx   = addr[AW+2:3];
  // Gating on the asynchronously reset state keeps a reset during ACCESS from writing.
  assign we    = (state == ACCESS) && is_wr && !bad_addr;
  assign rdata = (is_rd && !bad_addr) ? mem[idx] : '0;

  // Data memory write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (we)
      mem[idx] <= wdata;
  end

  // State register, operand latches and registered results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      code_q  <= '0;
      e_q     <= '0;
      a_q     <= '0;
      p_q     <= '0;
      val_m_q <= '0;
      stat_q  <= S_AOK;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        code_q <= in_code;
        e_q    <= val_e;
        a_q    <= val_a;
        p_q    <= val_p;
      end
      if (state == ACCESS) begin
        val_m_q <= rdata;
        stat_q  <= acc_stat;
      end
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = ACCESS;
      ACCESS:  begin busy = 1'b1; state_nx = RESP; end
      RESP: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = (stat_q == S_AOK) ? IDLE : STOP;
      end
      default: state_nx = STOP;
    endcase
  end

  assign val_m = val_m_q;
  assign stat  = stat_q;

endmodule
